// File: rtl/int_to_float_converter.sv
// Multi-cycle 32-bit integer to IEEE-754 single converter (truncating), one normalise shift per clock.
// Latency 2+(31-msb) clocks from start to done (1 for zero); start is ignored while busy.
module int_to_float_converter #(
  parameter bit SIGNED_IN = 1'b1,
  parameter int BIAS      = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] in_int,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        inexact
);

  typedef enum logic [1:0] {IDLE, NORM, PACK} state_t;

  localparam logic [7:0] EXP_SEED = 8'(BIAS + 31);

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        sign_q, sign_d;
  logic        zero_q, zero_d;
  logic [31:0] result_q, result_d;
  logic        inexact_q, inexact_d;
  logic        done_q, done_d;
  logic        in_neg;

  // Negating 0x80000000 wraps back to itself, which is exactly the magnitude we want.
  assign in_neg = SIGNED_IN && in_int[31];

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    sign_d    = sign_q;
    zero_d    = zero_q;
    result_d  = result_q;
    inexact_d = inexact_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = in_neg;
          mag_d   = in_neg ? (~in_int + 32'd1) : in_int;
          exp_d   = EXP_SEED;
          zero_d  = (in_int == 32'd0);
          state_d = (in_int == 32'd0) ? PACK : NORM;
        end
      end
      NORM: begin
        if (mag_q[31]) begin
          state_d = PACK;
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 8'd1;
        end
      end
      PACK: begin
        result_d  = zero_q ? 32'h0 : {sign_q, exp_q, mag_q[30:8]};
        inexact_d = zero_q ? 1'b0 : |mag_q[7:0];
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      mag_q     <= 32'd0;
      exp_q     <= 8'd0;
      sign_q    <= 1'b0;
      zero_q    <= 1'b0;
      result_q  <= 32'd0;
      inexact_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      sign_q    <= sign_d;
      zero_q    <= zero_d;
      result_q  <= result_d;
      inexact_q <= inexact_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign result  = result_q;
  assign inexact = inexact_q;

endmodule

// File: tb/tb_int_to_float_converter.sv
// Bench for int_to_float_converter: a signed and an unsigned instance, vector table,
// random operands against an arithmetic reference, and handshake/reset sequences.
module tb_int_to_float_converter;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_s, start_u;
  logic [31:0] in_s, in_u;
  logic        busy_s, busy_u, done_s, done_u, inx_s, inx_u;
  logic [31:0] res_s, res_u;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  int_to_float_converter #(.SIGNED_IN(1'b1), .BIAS(127)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .in_int(in_s),
    .busy(busy_s), .done(done_s), .result(res_s), .inexact(inx_s)
  );

  int_to_float_converter #(.SIGNED_IN(1'b0), .BIAS(127)) dut_u (
    .clk(clk), .reset(reset), .start(start_u), .in_int(in_u),
    .busy(busy_u), .done(done_u), .result(res_u), .inexact(inx_u)
  );

  typedef struct {
    string       name;
    bit          uns;
    logic [31:0] val;
    logic [31:0] exp_res;
    logic        exp_inx;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: value = 1.f * 2^p where p is the position of the leading one of |v|;
  // the fraction keeps the 23 bits below the leading one and drops the rest.
  function automatic void model(input bit uns, input logic [31:0] v,
                                output logic [31:0] r, output logic inx, output int lat);
    logic        neg;
    logic [31:0] m;
    logic [31:0] aligned;
    int          p;
    neg = !uns && v[31];
    m   = neg ? (32'd0 - v) : v;
    if (m == 32'd0) begin
      r = 32'd0; inx = 1'b0; lat = 1;
    end else begin
      p = 31;
      while (m[p] == 1'b0) p--;
      aligned = m << (31 - p);
      r   = {neg, 8'(127 + p), aligned[30:8]};
      inx = |aligned[7:0];
      lat = 2 + (31 - p);
    end
  endfunction

  // Called at a negedge; returns at the negedge where done is seen (or after the bound).
  task automatic convert(input bit uns, input logic [31:0] v,
                         output logic [31:0] r, output logic inx, output int lat);
    if (uns) begin start_u = 1'b1; in_u = v; end
    else     begin start_s = 1'b1; in_s = v; end
    @(posedge clk); @(negedge clk);
    start_u = 1'b0; start_s = 1'b0;
    chk("busy_after_start", 32'(uns ? busy_u : busy_s), 32'd1);
    lat = 0;
    while (!(uns ? done_u : done_s) && lat < 40) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    r   = uns ? res_u : res_s;
    inx = uns ? inx_u : inx_s;
  endtask

  task automatic run_vec(input string name, input bit uns, input logic [31:0] v,
                         input logic [31:0] er, input logic ei, input int el);
    logic [31:0] r;
    logic        inx;
    int          lat;
    convert(uns, v, r, inx, lat);
    chk({name, "_result"}, r, er);
    chk({name, "_inexact"}, 32'(inx), 32'(ei));
    chk({name, "_latency"}, 32'(lat), 32'(el));
  endtask

  initial begin
    vec_t        vecs[$];
    logic [31:0] mr;
    logic        mi;
    int          ml;
    int          pulses;
    int          first_done;
    logic [31:0] first_res;

    reset = 1'b1; start_s = 1'b0; start_u = 1'b0; in_s = '0; in_u = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    chk("reset_busy_s", 32'(busy_s), 32'd0);
    chk("reset_done_s", 32'(done_s), 32'd0);
    chk("reset_result_s", res_s, 32'd0);
    chk("reset_inexact_s", 32'(inx_s), 32'd0);
    chk("reset_busy_u", 32'(busy_u), 32'd0);
    chk("reset_result_u", res_u, 32'd0);

    vecs.push_back('{"one",      1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0, 33});
    vecs.push_back('{"minus1",   1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33});
    vecs.push_back('{"hundred",  1'b0, 32'd100,       32'h42C8_0000, 1'b0, 27});
    vecs.push_back('{"intmin",   1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0, 2});
    vecs.push_back('{"intmax",   1'b0, 32'h7FFF_FFFF, 32'h4EFF_FFFF, 1'b1, 3});
    vecs.push_back('{"zero",     1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{"u_max",    1'b1, 32'hFFFF_FFFF, 32'h4F7F_FFFF, 1'b1, 2});
    vecs.push_back('{"u_msb",    1'b1, 32'h8000_0000, 32'h4F00_0000, 1'b0, 2});
    vecs.push_back('{"u_zero",   1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0, 1});
    vecs.push_back('{"minus3",   1'b0, 32'hFFFF_FFFD, 32'hC040_0000, 1'b0, 32});
    foreach (vecs[i])
      run_vec(vecs[i].name, vecs[i].uns, vecs[i].val, vecs[i].exp_res, vecs[i].exp_inx, vecs[i].exp_lat);

    // Zero, then a new start presented in the cycle done is high.
    run_vec("b2b_zero", 1'b0, 32'd0, 32'h0, 1'b0, 1);
    chk("b2b_done_high", 32'(done_s), 32'd1);
    run_vec("b2b_hundred", 1'b0, 32'd100, 32'h42C8_0000, 1'b0, 27);
    @(posedge clk); @(negedge clk);
    chk("done_one_cycle", 32'(done_s), 32'd0);
    chk("result_held", res_s, 32'h42C8_0000);

    // A start while busy must neither restart nor alter the running conversion.
    start_s = 1'b1; in_s = 32'd1;
    @(posedge clk); @(negedge clk);
    start_s = 1'b0;
    pulses = 0; first_done = -1; first_res = '0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 4) begin start_s = 1'b1; in_s = 32'd5; end
      @(posedge clk); @(negedge clk);
      if (n == 4) begin start_s = 1'b0; in_s = 32'd0; end
      if (done_s) begin
        pulses++;
        if (first_done < 0) begin first_done = n; first_res = res_s; end
      end
    end
    chk("ignore_pulses", 32'(pulses), 32'd1);
    chk("ignore_latency", 32'(first_done), 32'd33);
    chk("ignore_result", first_res, 32'h3F80_0000);

    // Reset in the middle of a conversion aborts it without a done.
    start_s = 1'b1; in_s = 32'd1;
    @(posedge clk); @(negedge clk);
    start_s = 1'b0;
    repeat (9) begin @(posedge clk); @(negedge clk); end
    chk("midconv_busy", 32'(busy_s), 32'd1);
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("abort_busy", 32'(busy_s), 32'd0);
    chk("abort_done", 32'(done_s), 32'd0);
    chk("abort_result", res_s, 32'd0);
    chk("abort_inexact", 32'(inx_s), 32'd0);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (done_s) pulses++;
    end
    chk("abort_no_done", 32'(pulses), 32'd0);
    run_vec("after_abort", 1'b0, 32'd100, 32'h42C8_0000, 1'b0, 27);

    for (int i = 0; i < 150; i++) begin
      bit          uns;
      logic [31:0] v;
      uns = 1'($urandom_range(0, 1));
      v   = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) v = ~v;
      model(uns, v, mr, mi, ml);
      run_vec($sformatf("rand%0d", i), uns, v, mr, mi, ml);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
